// File: rtl/calc_pkg.sv
// Shared encodings and the result-entry layout for the calculator port responder.
package calc_pkg;

   localparam int unsigned CALC_DATA_W = 32;
   localparam int unsigned CALC_CMD_W  = 4;
   localparam int unsigned CALC_TAG_W  = 2;

   typedef enum logic [CALC_CMD_W-1:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [CALC_TAG_W-1:0] {
      RESP_NONE = 2'd0,
      RESP_OK   = 2'd1,
      RESP_ERR  = 2'd2
   } resp_e;

   typedef struct packed {
      resp_e                  resp;
      logic [CALC_DATA_W-1:0] data;
      logic [CALC_TAG_W-1:0]  tag;
   } result_t;

endpackage

// File: rtl/calc_result_fifo.sv
// Synchronous result FIFO with occupancy counter; read data is the current head entry.
module calc_result_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/calc_port_responder.sv
// Two-cycle command port: command+operand1, then operand2; results return in order via a FIFO.
module calc_port_responder
   import calc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CALC_DATA_W,
   parameter int unsigned CMD_WIDTH  = CALC_CMD_W,
   parameter int unsigned TAG_WIDTH  = CALC_TAG_W,
   parameter int unsigned FIFO_DEPTH = 2**TAG_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CMD_WIDTH-1:0]  cmd_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [TAG_WIDTH-1:0]  tag_in,
   output logic [TAG_WIDTH-1:0]  resp_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [TAG_WIDTH-1:0]  tag_out,
   output logic                  proto_err
);

   typedef enum logic {IDLE, OPND2} state_e;

   state_e                  state, state_nxt;
   logic                    accept, reject, compute;
   logic [CMD_WIDTH-1:0]    cmd_q;
   logic [DATA_WIDTH-1:0]   op1_q;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic [FIFO_DEPTH-1:0]   busy, set_mask, clr_mask;
   logic [DATA_WIDTH:0]     sum;
   result_t                 alu_res, stage_q, fifo_rd;
   logic                    stage_vld, fifo_push, fifo_empty, fifo_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = OPND2;
         OPND2:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept  = 1'b0;
      reject  = 1'b0;
      compute = 1'b0;
      case (state)
         IDLE: if (cmd_in != '0) begin
            if (busy[tag_in]) reject = 1'b1;
            else              accept = 1'b1;
         end
         OPND2:   compute = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      sum          = {1'b0, op1_q} + {1'b0, data_in};
      alu_res.resp = RESP_ERR;
      alu_res.data = '0;
      alu_res.tag  = tag_q;
      case (cmd_q)
         CMD_ADD: if (!sum[DATA_WIDTH]) begin
            alu_res.resp = RESP_OK;
            alu_res.data = sum[DATA_WIDTH-1:0];
         end
         CMD_SUB: if (data_in <= op1_q) begin
            alu_res.resp = RESP_OK;
            alu_res.data = op1_q - data_in;
         end
         CMD_SHL: begin
            alu_res.resp = RESP_OK;
            alu_res.data = op1_q << data_in[4:0];
         end
         CMD_SHR: begin
            alu_res.resp = RESP_OK;
            alu_res.data = op1_q >> data_in[4:0];
         end
         default: ;
      endcase
   end

   // A tag is freed at the edge ending the cycle its response is driven.
   assign set_mask  = accept ? (FIFO_DEPTH'(1) << tag_in) : '0;
   assign clr_mask  = (resp_out != '0) ? (FIFO_DEPTH'(1) << tag_out) : '0;
   assign fifo_push = stage_vld && !fifo_full;

   // The staging register adds the extra cycle so an entry never skips the FIFO on its way out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_q     <= '0;
         op1_q     <= '0;
         tag_q     <= '0;
         busy      <= '0;
         stage_vld <= 1'b0;
         stage_q   <= '0;
         proto_err <= 1'b0;
         resp_out  <= '0;
         data_out  <= '0;
         tag_out   <= '0;
      end else begin
         if (accept) begin
            cmd_q <= cmd_in;
            op1_q <= data_in;
            tag_q <= tag_in;
         end
         busy      <= (busy & ~clr_mask) | set_mask;
         stage_vld <= compute;
         if (compute) stage_q <= alu_res;
         proto_err <= reject;
         if (!fifo_empty) begin
            resp_out <= fifo_rd.resp;
            data_out <= fifo_rd.data;
            tag_out  <= fifo_rd.tag;
         end else begin
            resp_out <= '0;
            data_out <= '0;
            tag_out  <= '0;
         end
      end
   end

   calc_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(result_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (stage_q),
      .pop       (!fifo_empty),
      .pop_data  (fifo_rd),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule

// File: doc/calc_port_responder.md
CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, operand and result width.
REQ-002 Parameters SHALL be: CMD_WIDTH, default 4, command field width.
REQ-003 Parameters SHALL be: TAG_WIDTH, default 2, tag and response field width.
REQ-004 Parameters SHALL be: FIFO_DEPTH, default 4, which SHALL equal 2**TAG_WIDTH and sets the maximum number of outstanding results.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port cmd_in, input, CMD_WIDTH: command; 0 = no-op.
REQ-008 Port data_in, input, DATA_WIDTH: operand1 in the command cycle, operand2 in the following cycle.
REQ-009 Port tag_in, input, TAG_WIDTH: tag, valid in the command cycle.
REQ-010 Port resp_out, output, TAG_WIDTH: 0 = none, 1 = success, 2 = overflow/underflow/invalid command.
REQ-011 Port data_out, output, DATA_WIDTH: result, valid while resp_out != 0.
REQ-012 Port tag_out, output, TAG_WIDTH: tag of the returned result.
REQ-013 Port proto_err, output, 1: one-cycle pulse on a requester protocol violation.

Function
REQ-014 The FSM SHALL have two states: IDLE and OPND2.
- IDLE: nonzero cmd_in captures cmd, tag and operand1, then moves to OPND2.
- OPND2: captures data_in as operand2, computes the result, pushes {resp, data, tag} into the result FIFO and returns to IDLE unconditionally.
- cmd_in SHALL be ignored while in OPND2.
REQ-015 Command encodings:
- 1 add: op1+op2; carry out gives resp 2 with data 0.
- 2 sub: op1-op2, unsigned; op2>op1 gives resp 2 with data 0.
- 5 shift left: op1 << op2[4:0], resp 1.
- 6 shift right (logical): op1 >> op2[4:0], resp 1.
- Any other nonzero encoding: resp 2, data 0.
REQ-016 The output stage SHALL pop one FIFO entry per cycle into registered outputs.
- resp_out/data_out/tag_out SHALL be valid for exactly one cycle per entry.
- When no entry is popped, outputs SHALL be resp_out=0, data_out=0, tag_out=0.
REQ-017 Latency:
- The first response SHALL appear on the second rising edge after the OPND2 edge.
- Responses SHALL leave in acceptance order.
- There is no backpressure.
REQ-018 A tag SHALL be outstanding from command acceptance until the cycle its response is driven; outstanding tags are tracked in a FIFO_DEPTH-bit busy vector.
REQ-019 A command whose tag is already outstanding SHALL be dropped, pulse proto_err, and leave the FSM in IDLE.
REQ-020 The FIFO SHALL never overflow; REQ-019 guarantees at most FIFO_DEPTH entries.
REQ-021 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
- A push into an empty FIFO SHALL NOT bypass the output register.
REQ-022 A tag whose response is being driven in cycle N SHALL be accepted as a new command in cycle N+1.

Reset
REQ-023 Asserting reset low SHALL immediately force:
- FSM to IDLE
- FIFO empty
- busy vector to 0
- resp_out=0, data_out=0, tag_out=0, proto_err=0
REQ-024 Reset mid-transaction SHALL discard the pending operand1 and all queued results; no response SHALL follow deassertion.
REQ-025 Commands SHALL be accepted from the first rising edge after reset deasserts.

Structure
REQ-026 Shared package calc_pkg SHALL hold:
- command encodings as an enum (CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR)
- response encodings as an enum (RESP_NONE, RESP_OK, RESP_ERR)
- the packed result-entry struct {resp, data, tag}
REQ-027 The FIFO SHALL be a sub-module calc_result_fifo (parameterised depth and width; push/pop/empty/full).
- The FSM, ALU and output stage SHALL be in calc_port_responder.

Verification
REQ-028 Add: cmd=1, tag=0, op1=0x0000_0005, op2=0x0000_0003 -> resp=1, data=0x8, tag=0, two cycles after the operand2 edge.
REQ-029 Overflow and underflow:
- add 0xFFFF_FFFF + 0x1 -> resp=2, data=0.
- sub 0x3 - 0x5 -> resp=2, data=0.
REQ-030 Shifts and invalid command:
- SHL 0x1 by 0x24 -> data 0x10, since only op2[4:0] is used.
- SHR 0x8000_0000 by 31 -> data 0x1.
- cmd=4 -> resp=2, data 0.
REQ-031 Four back-to-back commands with tags 0-3 -> four consecutive responses in tag order 0,1,2,3.
- A fifth command reusing tag 2 before its response -> proto_err pulse, no fifth response.
REQ-032 Reset asserted between the command and operand2 cycles -> all outputs 0 immediately, no response after release, next command tag 0 accepted normally.
